div_unit: RTL and testbench
===========================

Name: div_unit

Overview:
Multi-cycle 32-bit integer divider serving the DIV/DIVU instructions of the 5-stage MIPS pipeline. It receives the two operands the decode stage delivers to EX (rs in opdata1_i, rt in opdata2_i). It uses a start/ready handshake and returns {remainder, quotient} for the HI/LO write path. EX holds start_i high and stalls the pipeline until ready_o is seen.

Parameters:
DATA_W, 32, operand width. Result width is 2*DATA_W. Iteration count is DATA_W.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  reset
signed_div_i  input  1  1 = DIV (signed), 0 = DIVU (unsigned); sampled with start_i
opdata1_i  input  DATA_W  dividend (rs)
opdata2_i  input  DATA_W  divisor (rt)
start_i  input  1  request; held high by EX until ready_o observed
annul_i  input  1  cancel in-flight division (flush/exception)
result_o  output  2*DATA_W  [63:32] remainder (HI), [31:0] quotient (LO)
ready_o  output  1  result_o valid

Behaviour:
- One clock (clk); reset is synchronous, active-high: rst=1 at a rising edge forces state FREE, ready_o=0, result_o=0, and clears the iteration counter and internal registers. This applies at any time, including mid-division.
- States: FREE, BY_ZERO, ON, END. All outputs are registered.
- In the timing below, edge 0 is the first rising edge at which start_i=1 is sampled in FREE.
- FREE:
  - If start_i=1 and annul_i=0 and divisor!=0: latch the operands and signed_div_i, then go to ON with counter=0.
  - If the signed flag is set, latch absolute values of the operands and record their signs.
  - If start_i=1 and annul_i=0 and divisor==0: go to BY_ZERO.
  - Otherwise stay in FREE. annul_i has priority over start_i.
- BY_ZERO: next edge goes to END with result_o=0, ready_o=1, i.e. ready_o is visible after edge 1.
- ON: one restoring-division step per edge:
  - Shift the partial remainder (DATA_W+1 bits) left, bringing in the next dividend MSB.
  - Trial-subtract the divisor. If the difference is non-negative, keep it and shift in quotient bit 1; else restore and shift in 0.
  - Counter increments on edges 1..32.
  - At edge 33 (counter==32), apply sign fix-up, register result_o, set ready_o=1 and go to END. First ready_o=1 is after edge 33.
- Sign fix-up (signed only):
  - Quotient is negated (two's complement) if operand signs differ.
  - Remainder takes the dividend's sign.
  - 0x80000000 / 0xFFFFFFFF yields quotient 0x80000000, remainder 0 (wraps, no trap).
- END:
  - result_o and ready_o are held while start_i=1.
  - At the first edge with start_i=0: go to FREE, ready_o=0, result_o=0.
  - annul_i is ignored in END.
- annul_i=1 in ON or BY_ZERO: next edge goes to FREE, ready_o stays 0, result_o=0, counter cleared.
- Input changes to opdata1_i, opdata2_i or signed_div_i after the start edge have no effect on an in-flight division.
- A new division can start at the earliest one edge after returning to FREE. Back-to-back start is not accepted in END.
- Unsigned mode treats the operands as unsigned DATA_W-bit values with no fix-up.

Test Plan:
- Unsigned 100/7 (signed_div_i=0, start_i held): ready_o=0 through edge 32, 1 after edge 33; result_o=0x00000002_0000000E. Drop start_i: next edge gives ready_o=0, result_o=0.
- Signed cases: -7/2 gives result_o=0xFFFFFFFF_FFFFFFFD. 7/-2 gives 0x00000001_FFFFFFFD. -8/-2 gives 0x00000000_00000004. 0x80000000/0xFFFFFFFF gives 0x00000000_80000000.
- Divide by zero: 5/0 gives ready_o=1 after edge 1 with result_o=0. Unsigned 0xFFFFFFFF/1 gives 0x00000000_FFFFFFFF after edge 33.
- annul_i pulsed at edge 10: FREE after edge 10, ready_o never asserts. A fresh 9/3 started afterwards returns 0x00000000_00000003 after its edge 33.
- rst=1 at edge 15 mid-division: outputs are 0 after that edge. Operands changed mid-ON (100/7 started, then inputs switched to 1/1) still return 0x00000002_0000000E.
- start_i with annul_i=1 in FREE: no start, state stays FREE, ready_o=0.

Source files
------------

// File: rtl/div_unit_if.sv
// Start/ready handshake between the EX stage and the multi-cycle divider.
//   signed_div_i : 1 = DIV (signed), 0 = DIVU (unsigned), sampled with start_i
//   opdata1_i    : dividend (rs)
//   opdata2_i    : divisor (rt)
//   start_i      : request, held high by EX until ready_o is seen
//   annul_i      : cancel an in-flight division (flush/exception)
//   result_o     : {remainder (HI), quotient (LO)}
//   ready_o      : result_o valid
// master = EX stage side, slave = divider side.
interface div_unit_if #(
    parameter int DATA_W = 32
);
    logic                  signed_div_i;
    logic [DATA_W-1:0]     opdata1_i;
    logic [DATA_W-1:0]     opdata2_i;
    logic                  start_i;
    logic                  annul_i;
    logic [2*DATA_W-1:0]   result_o;
    logic                  ready_o;

    modport master (
        output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        input  result_o, ready_o
    );

    modport slave (
        input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        output result_o, ready_o
    );
endinterface

// File: rtl/div_unit.sv
// Multi-cycle restoring divider for MIPS DIV/DIVU.
// Ports:
//   clk : system clock, rising edge
//   rst : synchronous active-high reset
//   bus : div_unit_if slave (operands, start/annul, result/ready)
// A division takes DATA_W restoring steps plus one sign fix-up edge; a
// zero divisor short-cuts to a zero result. Signed operands are divided as
// magnitudes and the signs are reapplied at the end.
module div_unit #(
    parameter int DATA_W = 32
) (
    input  logic       clk,
    input  logic       rst,
    div_unit_if.slave  bus
);
    localparam int CNT_W = $clog2(DATA_W) + 1;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DATA_W);

    typedef enum logic [1:0] {FREE, BY_ZERO, ON, END} state_t;

    state_t              state_q,   state_d;
    logic [CNT_W-1:0]    cnt_q,     cnt_d;
    logic [DATA_W-1:0]   dvd_q,     dvd_d;     // dividend bits shift out, quotient bits shift in
    logic [DATA_W-1:0]   dsr_q,     dsr_d;     // divisor magnitude
    logic [DATA_W:0]     rem_q,     rem_d;     // partial remainder, one guard bit
    logic                neg_quo_q, neg_quo_d;
    logic                neg_rem_q, neg_rem_d;
    logic [2*DATA_W-1:0] result_q,  result_d;
    logic                ready_q,   ready_d;

    logic [DATA_W-1:0]   op1_abs, op2_abs;
    logic                op1_neg, op2_neg;
    logic [DATA_W:0]     rem_shift, trial;
    logic [DATA_W-1:0]   quo_fix, rem_fix;

    assign op1_neg = bus.signed_div_i & bus.opdata1_i[DATA_W-1];
    assign op2_neg = bus.signed_div_i & bus.opdata2_i[DATA_W-1];
    // The most negative value maps onto itself, which is still correct
    // when the magnitude is read as unsigned.
    assign op1_abs = op1_neg ? -bus.opdata1_i : bus.opdata1_i;
    assign op2_abs = op2_neg ? -bus.opdata2_i : bus.opdata2_i;

    assign rem_shift = {rem_q[DATA_W-1:0], dvd_q[DATA_W-1]};
    assign trial     = rem_shift - {1'b0, dsr_q};

    assign quo_fix = neg_quo_q ? -dvd_q : dvd_q;
    assign rem_fix = neg_rem_q ? -rem_q[DATA_W-1:0] : rem_q[DATA_W-1:0];

    // NOTE: every signal driven here gets a default first so no path can leave it unassigned and infer a latch.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        dvd_d     = dvd_q;
        dsr_d     = dsr_q;
        rem_d     = rem_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        result_d  = result_q;
        ready_d   = ready_q;

        unique case (state_q)
            FREE: begin
                if (bus.start_i && !bus.annul_i) begin
                    if (bus.opdata2_i == '0) begin
                        state_d = BY_ZERO;
                    end else begin
                        state_d   = ON;
                        cnt_d     = '0;
                        rem_d     = '0;
                        dvd_d     = op1_abs;
                        dsr_d     = op2_abs;
                        neg_quo_d = op1_neg ^ op2_neg;
                        neg_rem_d = op1_neg;
                    end
                end
            end

            BY_ZERO: begin
                result_d = '0;
                if (bus.annul_i) begin
                    state_d = FREE;
                    ready_d = 1'b0;
                end else begin
                    state_d = END;
                    ready_d = 1'b1;
                end
            end

            ON: begin
                if (bus.annul_i) begin
                    state_d  = FREE;
                    cnt_d    = '0;
                    result_d = '0;
                    ready_d  = 1'b0;
                end else if (cnt_q == LAST_STEP) begin
                    state_d  = END;
                    result_d = {rem_fix, quo_fix};
                    ready_d  = 1'b1;
                end else begin
                    // Guard bit clear means the trial difference is non-negative.
                    if (!trial[DATA_W]) begin
                        rem_d = trial;
                        dvd_d = {dvd_q[DATA_W-2:0], 1'b1};
                    end else begin
                        rem_d = rem_shift;
                        dvd_d = {dvd_q[DATA_W-2:0], 1'b0};
                    end
                    cnt_d = cnt_q + 1'b1;
                end
            end

            END: begin
                if (!bus.start_i) begin
                    state_d  = FREE;
                    result_d = '0;
                    ready_d  = 1'b0;
                end
            end

            default: state_d = FREE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= FREE;
            cnt_q     <= '0;
            dvd_q     <= '0;
            dsr_q     <= '0;
            rem_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            result_q  <= '0;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            dvd_q     <= dvd_d;
            dsr_q     <= dsr_d;
            rem_q     <= rem_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            result_q  <= result_d;
            ready_q   <= ready_d;
        end
    end

    assign bus.result_o = result_q;
    assign bus.ready_o  = ready_q;
endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed steps in one initial block,
// expected results queued at start and compared when ready_o appears.
module tb_div_unit;
    localparam int DATA_W = 32;

    logic clk = 1'b0;
    logic rst;

    div_unit_if #(.DATA_W(DATA_W)) bus ();

    div_unit #(.DATA_W(DATA_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [63:0] exp_q[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Independent reference: language operators, zero divisor gives zero.
    function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic sgn);
        logic signed [31:0] sa, sb, sq, sr;
        if (b == 32'd0) return 64'd0;
        if (!sgn) return {a % b, a / b};
        sa = a;
        sb = b;
        sq = sa / sb;
        sr = sa % sb;
        return {sr, sq};
    endfunction

    // Starts a division, waits (bounded) for ready_o, checks latency and
    // result, then drops start_i and checks the return to idle.
    task automatic run_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic sgn, input logic [63:0] expected, input int exp_lat,
                           input bit mutate, input bit hold_check);
        int lat;
        logic [63:0] want;
        exp_q.push_back(expected);
        bus.opdata1_i    = a;
        bus.opdata2_i    = b;
        bus.signed_div_i = sgn;
        bus.start_i      = 1'b1;
        tick();                              // edge 0
        if (mutate) begin
            bus.opdata1_i    = 32'd1;
            bus.opdata2_i    = 32'd1;
            bus.signed_div_i = ~sgn;
        end
        lat = 0;
        while (bus.ready_o !== 1'b1 && lat < 40) begin
            tick();
            lat++;
        end
        check({tag, " latency"}, 64'(lat), 64'(exp_lat));
        want = exp_q.pop_front();
        check({tag, " result"}, bus.result_o, want);
        if (hold_check) begin
            tick();
            check({tag, " hold ready"}, 64'(bus.ready_o), 64'd1);
            check({tag, " hold result"}, bus.result_o, want);
        end
        bus.start_i = 1'b0;
        tick();
        check({tag, " idle ready"}, 64'(bus.ready_o), 64'd0);
        check({tag, " idle result"}, bus.result_o, 64'd0);
    endtask

    task automatic expect_quiet(input string tag, input int cycles);
        int seen = 0;
        for (int i = 0; i < cycles; i++) begin
            tick();
            if (bus.ready_o !== 1'b0) seen++;
        end
        check({tag, " no ready"}, 64'(seen), 64'd0);
    endtask

    initial begin
        logic [31:0] ra, rb;
        logic        rs;

        rst              = 1'b1;
        bus.start_i      = 1'b0;
        bus.annul_i      = 1'b0;
        bus.signed_div_i = 1'b0;
        bus.opdata1_i    = '0;
        bus.opdata2_i    = '0;
        tick();
        tick();
        check("reset ready", 64'(bus.ready_o), 64'd0);
        check("reset result", bus.result_o, 64'd0);
        rst = 1'b0;
        tick();

        run_div("u100/7", 32'd100, 32'd7, 1'b0, 64'h00000002_0000000E, 33, 1'b0, 1'b1);
        run_div("s-7/2", 32'hFFFFFFF9, 32'd2, 1'b1, 64'hFFFFFFFF_FFFFFFFD, 33, 1'b0, 1'b0);
        run_div("s7/-2", 32'd7, 32'hFFFFFFFE, 1'b1, 64'h00000001_FFFFFFFD, 33, 1'b0, 1'b0);
        run_div("s-8/-2", 32'hFFFFFFF8, 32'hFFFFFFFE, 1'b1, 64'h00000000_00000004, 33, 1'b0, 1'b0);
        run_div("s_min/-1", 32'h80000000, 32'hFFFFFFFF, 1'b1, 64'h00000000_80000000, 33, 1'b0, 1'b0);
        run_div("u_min/max", 32'h80000000, 32'hFFFFFFFF, 1'b0, 64'h80000000_00000000, 33, 1'b0, 1'b0);
        run_div("5/0", 32'd5, 32'd0, 1'b0, 64'd0, 1, 1'b0, 1'b1);
        run_div("umax/1", 32'hFFFFFFFF, 32'd1, 1'b0, 64'h00000000_FFFFFFFF, 33, 1'b0, 1'b0);

        // Annul at edge 10 of an in-flight division.
        bus.opdata1_i    = 32'd100;
        bus.opdata2_i    = 32'd7;
        bus.signed_div_i = 1'b0;
        bus.start_i      = 1'b1;
        tick();                              // edge 0
        for (int i = 1; i < 10; i++) tick();
        bus.annul_i = 1'b1;
        tick();                              // edge 10
        bus.annul_i = 1'b0;
        bus.start_i = 1'b0;
        check("annul ready", 64'(bus.ready_o), 64'd0);
        check("annul result", bus.result_o, 64'd0);
        expect_quiet("annul", 40);
        run_div("u9/3", 32'd9, 32'd3, 1'b0, 64'h00000000_00000003, 33, 1'b0, 1'b0);

        // Synchronous reset at edge 15 of an in-flight division.
        bus.opdata1_i = 32'd100;
        bus.opdata2_i = 32'd7;
        bus.start_i   = 1'b1;
        tick();                              // edge 0
        for (int i = 1; i < 15; i++) tick();
        rst         = 1'b1;
        bus.start_i = 1'b0;
        tick();                              // edge 15
        check("midrst ready", 64'(bus.ready_o), 64'd0);
        check("midrst result", bus.result_o, 64'd0);
        rst = 1'b0;
        expect_quiet("midrst", 40);

        // Operands switched to 1/1 (and mode flipped) right after the start edge.
        run_div("mutate", 32'd100, 32'd7, 1'b0, 64'h00000002_0000000E, 33, 1'b1, 1'b0);

        // start_i together with annul_i in FREE must not launch a division.
        bus.opdata1_i = 32'd50;
        bus.opdata2_i = 32'd5;
        bus.start_i   = 1'b1;
        bus.annul_i   = 1'b1;
        expect_quiet("start+annul", 40);
        bus.start_i = 1'b0;
        bus.annul_i = 1'b0;
        tick();

        for (int i = 0; i < 4; i++) begin
            ra = $urandom;
            rb = (i % 2 == 1) ? 32'($urandom_range(1, 5000)) : $urandom;
            rs = (i >= 2);
            if (rb == 32'd0) rb = 32'd3;
            if (rs && i == 3) rb = -rb;
            if (ra == 32'h80000000) ra = 32'd12345;
            run_div($sformatf("rand%0d", i), ra, rb, rs, model(ra, rb, rs), 33, 1'b0, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
